key_schedule_ctrl: RTL and testbench

//  Sequencer for the byte-serial AES-128 key register unit. Accepts the 16-byte cipher key over a

---
 rtl/key_schedule_ctrl.sv | 166 ++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
// Sequencer for the byte-serial AES-128 key register unit: key load handshake,
// one-hot key-unit strobes, round-constant generation and round-key valid flag.
module key_schedule_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       keyValid,
  output logic       keyReady,
  input  logic       stall,
  output logic       en,
  output logic       doSboxIn,
  output logic       doFirstSubkey,
  output logic       doKeyFirstCol,
  output logic       doKeyOtherCol,
  output logic [7:0] rcon,
  output logic       rconEn,
  output logic       roundKeyValid,
  output logic [3:0] roundIdx,
  output logic [3:0] byteIdx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FSUB, S_SBOX, S_FCOL, S_OCOL, S_DONE
  } state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e     state_q, state_d;
  logic [3:0] byteCnt_q, byteCnt_d;
  logic [3:0] roundCnt_q, roundCnt_d;
  logic [7:0] rcon_q, rcon_d;
  logic       step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byteCnt_q  <= 4'd0;
      roundCnt_q <= 4'd0;
      rcon_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      roundCnt_q <= roundCnt_d;
      rcon_q     <= rcon_d;
    end
  end

  // Everything except the LOAD handshake advances on every non-stalled cycle;
  // LOAD advances only when a key byte is actually accepted.
  always_comb begin
    state_d       = state_q;
    byteCnt_d     = byteCnt_q;
    roundCnt_d    = roundCnt_q;
    rcon_d        = rcon_q;
    keyReady      = 1'b0;
    en            = 1'b0;
    doSboxIn      = 1'b0;
    doFirstSubkey = 1'b0;
    doKeyFirstCol = 1'b0;
    doKeyOtherCol = 1'b0;
    rconEn        = 1'b0;
    roundKeyValid = 1'b0;
    done          = 1'b0;
    busy          = (state_q != S_IDLE);
    step          = ~stall;

    case (state_q)
      S_IDLE: begin
        if (start && step) begin
          state_d    = S_LOAD;
          byteCnt_d  = 4'd0;
          roundCnt_d = 4'd0;
          rcon_d     = 8'h00;
        end
      end
      S_LOAD: begin
        keyReady = step;
        en       = keyValid & step;
        if (en) begin
          if (byteCnt_q == 4'd15) begin
            state_d   = S_FSUB;
            byteCnt_d = 4'd0;
          end else begin
            byteCnt_d = byteCnt_q + 4'd1;
          end
        end
      end
      S_FSUB: begin
        doFirstSubkey = step;
        roundKeyValid = step;
        if (step) begin
          if (byteCnt_q == 4'd15) begin
            state_d    = S_SBOX;
            byteCnt_d  = 4'd0;
            roundCnt_d = 4'd1;
            rcon_d     = 8'h01;
          end else begin
            byteCnt_d = byteCnt_q + 4'd1;
          end
        end
      end
      S_SBOX: begin
        doSboxIn = step;
        if (step) begin
          if (byteCnt_q == 4'd3) begin
            state_d   = S_FCOL;
            byteCnt_d = 4'd0;
          end else begin
            byteCnt_d = byteCnt_q + 4'd1;
          end
        end
      end
      S_FCOL: begin
        doKeyFirstCol = step;
        roundKeyValid = step;
        rconEn        = step && (byteCnt_q == 4'd0);
        if (step) begin
          if (byteCnt_q == 4'd3) begin
            state_d   = S_OCOL;
            byteCnt_d = 4'd0;
          end else begin
            byteCnt_d = byteCnt_q + 4'd1;
          end
        end
      end
      S_OCOL: begin
        doKeyOtherCol = step;
        roundKeyValid = step;
        if (step) begin
          if (byteCnt_q == 4'd11) begin
            byteCnt_d = 4'd0;
            if (roundCnt_q < NR_L) begin
              // Next Rcon is the GF(2^8) doubling of the current one.
              state_d    = S_SBOX;
              roundCnt_d = roundCnt_q + 4'd1;
              rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
            end else begin
              state_d = S_DONE;
            end
          end else begin
            byteCnt_d = byteCnt_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        done = step;
        if (step) begin
          state_d    = S_IDLE;
          byteCnt_d  = 4'd0;
          roundCnt_d = 4'd0;
          rcon_d     = 8'h00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rcon     = rcon_q;
  assign roundIdx = roundCnt_q;
  assign byteIdx  = byteCnt_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: two instances (NR=10, NR=1) driven
// in lockstep and compared every cycle against a schedule-list reference model.
module tb_key_schedule_ctrl;

  typedef enum int {K_LOAD, K_FSUB, K_SBOX, K_FCOL, K_OCOL, K_DONE} kind_e;

  typedef struct {
    kind_e      kind;
    int         byteN;
    int         round;
    logic [7:0] rc;
  } slot_t;

  typedef struct packed {
    logic       ready, en, sbox, fsub, fcol, ocol;
    logic [7:0] rc;
    logic       rce, rkv;
    logic [3:0] ri, bi;
    logic       bsy, dn;
  } obs_t;

  typedef struct {
    logic       rst, start, kv, stall;
    logic       busy, ready, en;
    logic [3:0] byteN;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic keyValid = 1'b0;
  logic stall = 1'b0;

  logic       keyReady [2];
  logic       en [2];
  logic       doSboxIn [2];
  logic       doFirstSubkey [2];
  logic       doKeyFirstCol [2];
  logic       doKeyOtherCol [2];
  logic [7:0] rcon [2];
  logic       rconEn [2];
  logic       roundKeyValid [2];
  logic [3:0] roundIdx [2];
  logic [3:0] byteIdx [2];
  logic       busy [2];
  logic       done [2];

  always #5 clk = ~clk;

  key_schedule_ctrl #(.NR(10)) dut10 (
    .clk(clk), .rst(rst), .start(start), .keyValid(keyValid), .keyReady(keyReady[0]),
    .stall(stall), .en(en[0]), .doSboxIn(doSboxIn[0]), .doFirstSubkey(doFirstSubkey[0]),
    .doKeyFirstCol(doKeyFirstCol[0]), .doKeyOtherCol(doKeyOtherCol[0]), .rcon(rcon[0]),
    .rconEn(rconEn[0]), .roundKeyValid(roundKeyValid[0]), .roundIdx(roundIdx[0]),
    .byteIdx(byteIdx[0]), .busy(busy[0]), .done(done[0])
  );

  key_schedule_ctrl #(.NR(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .keyValid(keyValid), .keyReady(keyReady[1]),
    .stall(stall), .en(en[1]), .doSboxIn(doSboxIn[1]), .doFirstSubkey(doFirstSubkey[1]),
    .doKeyFirstCol(doKeyFirstCol[1]), .doKeyOtherCol(doKeyOtherCol[1]), .rcon(rcon[1]),
    .rconEn(rconEn[1]), .roundKeyValid(roundKeyValid[1]), .roundIdx(roundIdx[1]),
    .byteIdx(byteIdx[1]), .busy(busy[1]), .done(done[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: the whole run is a flat list of slots; pos = -1 means idle.
  int    nrOf [2] = '{10, 1};
  slot_t sched [2][0:255];
  int    schedLen [2];
  int    pos [2] = '{-1, -1};

  int         enCount [2], enFirst [2], enLast [2], rkvCount [2];
  int         fsubFirst [2], doneCyc [2];
  int         rceCount, onehotBad, stallStrobes;
  logic [7:0] rceVals [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rconOf(input int r);
    if (r <= 8) return 8'(1 << (r - 1));
    else if (r == 9) return 8'h1B;
    else return 8'h36;
  endfunction

  function automatic slot_t mk(input kind_e k, input int b, input int r, input logic [7:0] c);
    slot_t s;
    s.kind = k; s.byteN = b; s.round = r; s.rc = c;
    return s;
  endfunction

  task automatic buildSched(input int m);
    int n = 0;
    for (int i = 0; i < 16; i++) begin sched[m][n] = mk(K_LOAD, i, 0, 8'h00); n++; end
    for (int i = 0; i < 16; i++) begin sched[m][n] = mk(K_FSUB, i, 0, 8'h00); n++; end
    for (int r = 1; r <= nrOf[m]; r++) begin
      for (int i = 0; i < 4; i++)  begin sched[m][n] = mk(K_SBOX, i, r, rconOf(r)); n++; end
      for (int i = 0; i < 4; i++)  begin sched[m][n] = mk(K_FCOL, i, r, rconOf(r)); n++; end
      for (int i = 0; i < 12; i++) begin sched[m][n] = mk(K_OCOL, i, r, rconOf(r)); n++; end
    end
    sched[m][n] = mk(K_DONE, 0, nrOf[m], rconOf(nrOf[m]));
    n++;
    schedLen[m] = n;
  endtask

  function automatic obs_t expectOf(input int m);
    obs_t  e;
    slot_t s;
    logic  act;
    e = '0;
    if (pos[m] < 0) return e;
    s   = sched[m][pos[m]];
    act = !stall;
    e.bsy = 1'b1;
    e.ri  = 4'(s.round);
    e.bi  = 4'(s.byteN);
    e.rc  = s.rc;
    case (s.kind)
      K_LOAD: begin e.ready = act; e.en = act && keyValid; end
      K_FSUB: begin e.fsub = act; e.rkv = act; end
      K_SBOX: e.sbox = act;
      K_FCOL: begin e.fcol = act; e.rkv = act; e.rce = act && (s.byteN == 0); end
      K_OCOL: begin e.ocol = act; e.rkv = act; end
      default: e.dn = act;
    endcase
    return e;
  endfunction

  function automatic obs_t actualOf(input int m);
    obs_t a;
    a.ready = keyReady[m]; a.en = en[m]; a.sbox = doSboxIn[m]; a.fsub = doFirstSubkey[m];
    a.fcol = doKeyFirstCol[m]; a.ocol = doKeyOtherCol[m]; a.rc = rcon[m]; a.rce = rconEn[m];
    a.rkv = roundKeyValid[m]; a.ri = roundIdx[m]; a.bi = byteIdx[m]; a.bsy = busy[m];
    a.dn = done[m];
    return a;
  endfunction

  // Model view of the coming clock edge.
  task automatic modelStep(input int m);
    if (rst) pos[m] = -1;
    else if (pos[m] < 0) begin
      if (start && !stall) pos[m] = 0;
    end else if (!stall) begin
      if (sched[m][pos[m]].kind != K_LOAD || keyValid) begin
        pos[m]++;
        if (pos[m] >= schedLen[m]) pos[m] = -1;
      end
    end
  endtask

  task automatic resetTrackers();
    for (int m = 0; m < 2; m++) begin
      enCount[m] = 0; enFirst[m] = -1; enLast[m] = -1; rkvCount[m] = 0;
      fsubFirst[m] = -1; doneCyc[m] = -1;
    end
    rceCount = 0; onehotBad = 0; stallStrobes = 0;
  endtask

  task automatic checkOutput();
    obs_t a;
    for (int m = 0; m < 2; m++) begin
      a = actualOf(m);
      check($sformatf("obs nr%0d cyc%0d", nrOf[m], cyc), 32'(a), 32'(expectOf(m)));
      if (a.en) begin enCount[m]++; if (enFirst[m] < 0) enFirst[m] = cyc; enLast[m] = cyc; end
      if (a.rkv) rkvCount[m]++;
      if (a.fsub && fsubFirst[m] < 0) fsubFirst[m] = cyc;
      if (a.dn && doneCyc[m] < 0) doneCyc[m] = cyc;
      if ($countones({a.en, a.sbox, a.fsub, a.fcol, a.ocol}) > 1) onehotBad++;
      if (stall && (a.ready | a.en | a.sbox | a.fsub | a.fcol | a.ocol | a.rce | a.rkv | a.dn))
        stallStrobes++;
    end
    if (rconEn[0]) begin
      if (rceCount < 16) rceVals[rceCount] = rcon[0];
      rceCount++;
    end
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle, advance model.
  task automatic applyStimulus(input logic st, input logic kv, input logic sl, input logic rs);
    @(posedge clk);
    #1;
    start = st; keyValid = kv; stall = sl; rst = rs;
    #4;
    checkOutput();
    modelStep(0);
    modelStep(1);
    cyc++;
  endtask

  task automatic runFor(input int m, input int budget);
    int n = 0;
    while (doneCyc[m] < 0 && n < budget) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check($sformatf("done seen nr%0d", nrOf[m]), 32'(doneCyc[m] >= 0), 32'd1);
  endtask

  vec_t       vecs [8];
  logic [7:0] expRcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  int         c0, c1;

  initial begin
    buildSched(0);
    buildSched(1);
    resetTrackers();

    //            rst  st   kv   stl  busy rdy  en   byte
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset busy", 32'(busy[0]), 32'd0);
    check("reset rcon", 32'(rcon[0]), 32'h00);
    check("reset roundIdx", 32'(roundIdx[0]), 32'd0);

    // Handshake / stall / reset-abort table at the start of LOAD.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].start, vecs[i].kv, vecs[i].stall, vecs[i].rst);
      for (int m = 0; m < 2; m++) begin
        check($sformatf("vec%0d busy nr%0d", i, nrOf[m]), 32'(busy[m]), 32'(vecs[i].busy));
        check($sformatf("vec%0d ready nr%0d", i, nrOf[m]), 32'(keyReady[m]), 32'(vecs[i].ready));
        check($sformatf("vec%0d en nr%0d", i, nrOf[m]), 32'(en[m]), 32'(vecs[i].en));
        check($sformatf("vec%0d byteIdx nr%0d", i, nrOf[m]), 32'(byteIdx[m]), 32'(vecs[i].byteN));
      end
    end

    // Full run with keyValid held high; Rcon trace and one-hot strobes.
    resetTrackers();
    c0 = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    runFor(0, 300);
    check("T1 en count", 32'(enCount[0]), 32'd16);
    check("T1 en first", 32'(enFirst[0] - c0), 32'd1);
    check("T1 en last", 32'(enLast[0] - c0), 32'd16);
    check("T1 done nr10", 32'(doneCyc[0] - c0), 32'd233);
    check("T1 done nr1", 32'(doneCyc[1] - c0), 32'd53);
    check("T1 rkv nr10", 32'(rkvCount[0]), 32'd176);
    check("T2 rconEn count", 32'(rceCount), 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("T2 rcon%0d", i + 1), 32'(rceVals[i]), 32'(expRcon[i]));
    check("T2 one-hot", 32'(onehotBad), 32'd0);

    // keyValid alternating during LOAD.
    resetTrackers();
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 31; k++) applyStimulus(1'b0, 1'(k % 2), 1'b0, 1'b0);
    runFor(0, 300);
    check("T3 en count", 32'(enCount[0]), 32'd16);
    check("T3 en last", 32'(enLast[0] - c0), 32'd31);
    check("T3 fsub first", 32'(fsubFirst[0] - c0), 32'd32);
    check("T3 done nr10", 32'(doneCyc[0] - c0), 32'd248);
    check("T3 done nr1", 32'(doneCyc[1] - c0), 32'd68);

    // Five stall cycles inside OCOL of round 3.
    resetTrackers();
    c0 = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 300 && doneCyc[0] < 0; k++)
      applyStimulus(1'b0, 1'b1, 1'(k >= 85 && k <= 89), 1'b0);
    check("T4 done delayed", 32'(doneCyc[0] - c0), 32'd238);
    check("T4 strobes in stall", 32'(stallStrobes), 32'd0);

    // Reset mid-run, then a fresh run.
    c0 = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 99; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check("T5 busy after rst", 32'(busy[0]), 32'd0);
    check("T5 rcon after rst", 32'(rcon[0]), 32'h00);
    check("T5 roundIdx after rst", 32'(roundIdx[0]), 32'd0);
    resetTrackers();
    c1 = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    runFor(0, 300);
    check("T5 done after restart", 32'(doneCyc[0] - c1), 32'd233);

    // NR=1 with start pulsed while busy and in the DONE cycle.
    resetTrackers();
    c0 = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1'(k == 20 || k == 53), 1'b1, 1'b0, 1'b0);
      if (k == 54) check("T6 idle after done", 32'(busy[1]), 32'd0);
    end
    check("T6 done nr1", 32'(doneCyc[1] - c0), 32'd53);
    check("T6 rkv nr1", 32'(rkvCount[1]), 32'd32);
    runFor(0, 300);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++)
      applyStimulus(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 299) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
